// File: rtl/if_batch_fetch.sv
// Instruction-fetch front end: batch-aligned I$ requests, a small response FIFO
// toward decode, and redirect handling that flushes the FIFO and drops stale responses.
//
// state  | meaning
// WARMUP | idle after reset until the warmup down-counter expires
// FETCH  | request the current batch when the FIFO has room
// WAIT   | one request accepted, waiting for its response
// DROP   | response still pending for a request issued before a redirect
module if_batch_fetch #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    INST_WIDTH    = 32,
    parameter int                    BATCH         = 2,
    parameter int                    FIFO_DEPTH    = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = 32'h8000_0000,
    parameter int                    WARMUP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_valid,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic                        imem_req_valid,
    output logic [ADDR_WIDTH-1:0]       imem_req_addr,
    input  logic                        imem_req_ready,
    input  logic                        imem_rsp_valid,
    input  logic [BATCH*INST_WIDTH-1:0] imem_rsp_data,
    output logic                        out_valid,
    output logic [BATCH*INST_WIDTH-1:0] out_inst,
    output logic [BATCH-1:0]            out_mask,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    input  logic                        out_ready
);

    localparam int DW      = BATCH * INST_WIDTH;
    localparam int B_BYTES = BATCH * 4;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int WCNT_W  = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(B_BYTES - 1);

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_DROP   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (WARMUP_CYCLES == 0) ? S_FETCH : S_WARMUP;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   base;
    logic [WCNT_W-1:0]       warm_cnt;
    logic [BATCH-1:0]        lane_mask;
    logic [ADDR_WIDTH-1:0]   req_base;
    logic [BATCH-1:0]        req_mask;

    logic [DW-1:0]           fifo_data [FIFO_DEPTH];
    logic [BATCH-1:0]        fifo_mask [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_base [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;

    logic fifo_full;
    logic req_fire;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign base      = pc & ~OFF_MASK;
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));

    // A lane is valid when its address is at or beyond pc (redirect into mid-batch).
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BATCH; i++) begin
            lane_mask[i] = ((base | ADDR_WIDTH'(4 * i)) >= pc);
        end
    end

    assign imem_req_valid = (state == S_FETCH) && !fifo_full && !redirect_valid;
    assign imem_req_addr  = base;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign out_valid      = (count != '0);
    assign pop            = out_valid && out_ready && !redirect_valid;

    assign out_inst = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_mask = out_valid ? fifo_mask[rd_ptr] : '0;
    assign out_pc   = out_valid ? fifo_base[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_WARMUP: if (warm_cnt <= WCNT_W'(1)) state_nxt = S_FETCH;
            S_FETCH:  if (req_fire) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid)      state_nxt = S_FETCH;
                else if (redirect_valid) state_nxt = S_DROP;
            end
            S_DROP:   if (imem_rsp_valid) state_nxt = S_FETCH;
            default:  state_nxt = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            pc       <= RESET_PC;
            warm_cnt <= WCNT_W'(WARMUP_CYCLES);
            req_base <= '0;
            req_mask <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WARMUP) warm_cnt <= warm_cnt - WCNT_W'(1);
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (req_fire) begin
                pc       <= base + ADDR_WIDTH'(B_BYTES);
                req_base <= base;
                req_mask <= lane_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_mask[wr_ptr] <= req_mask;
            fifo_base[wr_ptr] <= req_base;
        end
    end

endmodule
